// File: rtl/rtype_result_checker_if.sv
// rtype_result_checker bus: run handshake, table load and result outputs.
// master drives stimulus/table, slave is the checker.
interface rtype_result_checker_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              start;
  logic [ADDR_W:0]   n_checks;
  logic [DATA_W-1:0] resultado;
  logic              exp_we;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] exp_mask;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W:0]   err_count;
  logic [ADDR_W-1:0] first_err_idx;
  logic [DATA_W-1:0] first_err_got;

  modport master (
    output start, n_checks, resultado,
    output exp_we, exp_addr, exp_data, exp_mask,
    input  busy, done, pass,
    input  err_count, first_err_idx, first_err_got
  );

  modport slave (
    input  start, n_checks, resultado,
    input  exp_we, exp_addr, exp_data, exp_mask,
    output busy, done, pass,
    output err_count, first_err_idx, first_err_got
  );
endinterface

// File: rtl/rtype_result_checker.sv
// Compares CPU resultado against a preloaded expected table, one per cycle.
// Define CHECKER_MASK_EN to store a per-entry compare mask.
module rtype_result_checker #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int SKIP   = 1
) (
  input  logic                 clk_CPU,
  input  logic                 rst_CPU_n,
  rtype_result_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SKIP,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]      L_SKIP  = 8'(SKIP);

  state_t            r_state;
  logic [DATA_W-1:0] r_tab [DEPTH];
`ifdef CHECKER_MASK_EN
  logic [DATA_W-1:0] r_msk [DEPTH];
`endif
  logic [7:0]        r_skip;
  logic [ADDR_W:0]   r_n;
  logic [ADDR_W-1:0] r_idx;
  logic              r_busy;
  logic              r_done;
  logic              r_pass;
  logic [ADDR_W:0]   r_err;
  logic [ADDR_W-1:0] r_fidx;
  logic [DATA_W-1:0] r_fgot;

  logic              w_open;
  logic [ADDR_W:0]   w_n;
  logic              w_mism;
  logic              w_last;
  logic [ADDR_W:0]   w_err_nxt;

  assign w_open = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_n    = (bus.n_checks > L_DEPTH) ? L_DEPTH : bus.n_checks;

`ifdef CHECKER_MASK_EN
  assign w_mism = |((bus.resultado ^ r_tab[r_idx]) & r_msk[r_idx]);
`else
  assign w_mism = (bus.resultado != r_tab[r_idx]);
  logic w_unused_mask;
  assign w_unused_mask = ^bus.exp_mask;
`endif

  assign w_last    = ({1'b0, r_idx} == (r_n - 1'b1));
  assign w_err_nxt = r_err + {{ADDR_W{1'b0}}, w_mism};

  // Expected table: writable only between runs, never reset.
  always_ff @(posedge clk_CPU) begin
    if (bus.exp_we && w_open) begin
      r_tab[bus.exp_addr] <= bus.exp_data;
`ifdef CHECKER_MASK_EN
      r_msk[bus.exp_addr] <= bus.exp_mask;
`endif
    end
  end

  // Run control, compare counting and first-failure capture.
  always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
    if (!rst_CPU_n) begin
      r_state <= S_IDLE;
      r_skip  <= '0;
      r_n     <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_fidx  <= '0;
      r_fgot  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_n    <= w_n;
            r_idx  <= '0;
            r_err  <= '0;
            r_fidx <= '0;
            r_fgot <= '0;
            if (w_n == '0) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else if (L_SKIP != 8'd0) begin
              r_state <= S_SKIP;
              r_skip  <= L_SKIP;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_pass  <= 1'b0;
            end
          end
        end
        S_SKIP: begin
          r_skip <= r_skip - 8'd1;
          if (r_skip == 8'd1) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_err <= w_err_nxt;
          r_idx <= r_idx + 1'b1;
          if (w_mism && (r_err == '0)) begin
            r_fidx <= r_idx;
            r_fgot <= bus.resultado;
          end
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_nxt == '0);
          end
        end
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err;
  assign bus.first_err_idx = r_fidx;
  assign bus.first_err_got = r_fgot;

endmodule

// File: tb/tb_rtype_result_checker.sv
// Bench for rtype_result_checker: vector table, hand sequences,
// and random runs against a simple counting model.
module tb_rtype_result_checker;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int SKIP  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rtype_result_checker_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  rtype_result_checker #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .SKIP(SKIP)
  ) dut (
    .clk_CPU  (clk),
    .rst_CPU_n(rst_n),
    .bus      (bus)
  );

  typedef struct {
    int          n;
    logic [15:0] eb;
    logic [31:0] xv;
    int          err;
    int          fidx;
    logic [31:0] fgot;
    bit          pass;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] tab_m [DEPTH];
  logic [DW-1:0] drv [DEPTH];
  vec_t vt [7];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d,
                    input logic [DW-1:0] m);
    bus.exp_we   = 1'b1;
    bus.exp_addr = AW'(a);
    bus.exp_data = d;
    bus.exp_mask = m;
    @(posedge clk);
    @(negedge clk);
    bus.exp_we = 1'b0;
    tab_m[a]   = d;
  endtask

  task automatic run(input int n, input int pulse_k);
    int nn;
    nn = (n > DEPTH) ? DEPTH : n;
    bus.start    = 1'b1;
    bus.n_checks = (AW+1)'(n);
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.exp_we = 1'b0;
    if (nn == 0) begin
      chk("zero_done", bus.done, 1);
      chk("zero_busy", bus.busy, 0);
      return;
    end
    chk("busy_on", bus.busy, 1);
    chk("done_off", bus.done, 0);
    repeat (SKIP) begin
      @(posedge clk);
      @(negedge clk);
    end
    for (int k = 0; k < nn; k++) begin
      bus.resultado = drv[k];
      if (k == pulse_k) begin
        bus.start    = 1'b1;
        bus.n_checks = 5'd1;
        bus.exp_we   = 1'b1;
        bus.exp_addr = AW'(nn - 1);
        bus.exp_data = ~tab_m[nn-1];
      end
      @(posedge clk);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.exp_we = 1'b0;
      if (k == nn - 2) begin
        chk("done_early", bus.done, 0);
        chk("busy_mid", bus.busy, 1);
      end
    end
    chk("done_on", bus.done, 1);
    chk("busy_off", bus.busy, 0);
  endtask

  task automatic res(input string nm, input int err, input int fidx,
                     input logic [31:0] fgot, input bit pass);
    chk({nm, "_err"}, bus.err_count, err);
    chk({nm, "_pass"}, bus.pass, pass);
    if (err != 0) begin
      chk({nm, "_fidx"}, bus.first_err_idx, fidx);
      chk({nm, "_fgot"}, bus.first_err_got, fgot);
    end
  endtask

  initial begin
    int n, nn, err, fi;
    logic [31:0] fg;

    bus.start     = 1'b0;
    bus.n_checks  = '0;
    bus.resultado = '0;
    bus.exp_we    = 1'b0;
    bus.exp_addr  = '0;
    bus.exp_data  = '0;
    bus.exp_mask  = '1;

    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass, 0);
    chk("rst_err", bus.err_count, 0);
    chk("rst_fidx", bus.first_err_idx, 0);
    chk("rst_fgot", bus.first_err_got, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wr(0, 32'd5, '1);
    wr(1, 32'd9, '1);
    wr(2, 32'hFFFF_FFFF, '1);
    wr(3, 32'd0, '1);
    for (int i = 4; i < DEPTH; i++)
      wr(i, 32'(i) * 32'h0101_0101 + 32'd3, '1);

    vt[0] = '{4,  16'h0000, 32'h0,         0, 0,  32'h0,         1'b1};
    vt[1] = '{4,  16'h0002, 32'h0000_000E, 1, 1,  32'h7,         1'b0};
    vt[2] = '{0,  16'h0000, 32'h0,         0, 0,  32'h0,         1'b1};
    vt[3] = '{31, 16'h8000, 32'h1,         1, 15, 32'h0F0F_0F13, 1'b0};
    vt[4] = '{4,  16'h0010, 32'h1,         0, 0,  32'h0,         1'b1};
    vt[5] = '{16, 16'h8001, 32'hFF,        2, 0,  32'hFA,        1'b0};
    vt[6] = '{2,  16'h0003, 32'h8000_0000, 2, 0,  32'h8000_0005, 1'b0};

    for (int v = 0; v < 7; v++) begin
      for (int k = 0; k < DEPTH; k++)
        drv[k] = tab_m[k] ^ (vt[v].eb[k] ? vt[v].xv : 32'h0);
      run(vt[v].n, -1);
      res($sformatf("vec%0d", v), vt[v].err, vt[v].fidx,
          vt[v].fgot, vt[v].pass);
    end

    // write in the same cycle as start is seen by the run
    bus.exp_we   = 1'b1;
    bus.exp_addr = '0;
    bus.exp_data = 32'hA5A5_A5A5;
    bus.exp_mask = '1;
    tab_m[0]     = 32'hA5A5_A5A5;
    for (int k = 0; k < DEPTH; k++) drv[k] = tab_m[k];
    run(1, -1);
    res("wr_start", 0, 0, 32'h0, 1'b1);

    // start and exp_we during RUN ignored
    run(4, 0);
    res("ign_run", 0, 0, 32'h0, 1'b1);
    run(4, -1);
    res("ign_tab", 0, 0, 32'h0, 1'b1);

    // async reset mid-run
    drv[0] = tab_m[0] ^ 32'h1;
    bus.start    = 1'b1;
    bus.n_checks = 5'd4;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.resultado = drv[0];
    @(posedge clk);
    @(negedge clk);
    bus.resultado = drv[1];
    chk("mid_err", bus.err_count, 1);
    chk("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_pass", bus.pass, 0);
    chk("ar_err", bus.err_count, 0);
    chk("ar_fidx", bus.first_err_idx, 0);
    chk("ar_fgot", bus.first_err_got, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drv[0] = tab_m[0];
    run(4, -1);
    res("post_rst", 0, 0, 32'h0, 1'b1);

    // random runs against a counting model
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < DEPTH; i++) wr(i, $urandom, '1);
      n  = $urandom_range(0, 31);
      nn = (n > DEPTH) ? DEPTH : n;
      for (int k = 0; k < DEPTH; k++)
        drv[k] = ($urandom_range(0, 3) == 0) ?
                 (tab_m[k] ^ ($urandom | 32'h1)) : tab_m[k];
      err = 0;
      fi  = 0;
      fg  = '0;
      for (int k = 0; k < nn; k++) begin
        if (drv[k] != tab_m[k]) begin
          if (err == 0) begin
            fi = k;
            fg = drv[k];
          end
          err++;
        end
      end
      run(n, -1);
      res($sformatf("rnd%0d", r), err, fi, fg, err == 0);
    end

    // masked compare
    wr(0, 32'h1234_5678, 32'hFFFF_0000);
    drv[0] = 32'h1234_ABCD;
    run(1, -1);
`ifdef CHECKER_MASK_EN
    res("mask", 0, 0, 32'h0, 1'b1);
`else
    res("mask", 1, 0, 32'h1234_ABCD, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
